wallace_mult_pipe: RTL and testbench

WALLACE_MULT_PIPE -- requirements
Module: wallace_mult_pipe

---
 rtl/wallace_pkg.sv | 47 ++++
 rtl/fullAdder.sv | 12 +
 rtl/halfAdder.sv | 11 +
 rtl/wallace_reduce_level.sv | 49 ++++
 rtl/wallace_mult_pipe.sv | 177 +++++++++++++++++
 tb/tb_wallace_mult_pipe.sv | 311 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/wallace_pkg.sv
// Shared limits and elaboration helpers for the Wallace multiplier.
// Tree depth and pipeline-register placement are derived here.
package wallace_pkg;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 32;
  localparam int PIPE_MIN  = 1;
  localparam int PIPE_MAX  = 3;

  function automatic int latency(input int stages);
    return stages;
  endfunction

  function automatic int next_rows(input int r);
    return 2 * (r / 3) + r % 3;
  endfunction

  function automatic int num_levels(input int r);
    int n;
    int x;
    n = 0;
    x = r;
    while (x > 2) begin
      x = next_rows(x);
      n++;
    end
    return n;
  endfunction

  function automatic int rows_at(input int r, input int l);
    int x;
    x = r;
    for (int i = 0; i < l; i++) x = next_rows(x);
    return x;
  endfunction

  // Nonzero S: register S-1 (1-based S) sits in front of level l.
  function automatic int stage_at(input int l, input int levels,
                                  input int stages);
    int s;
    s = 0;
    for (int k = 0; k < stages - 1; k++)
      if (((k + 1) * levels) / stages == l) s = k + 1;
    return s;
  endfunction

endpackage

// File: rtl/fullAdder.sv
// One-bit full adder cell.
// Used by the reduction levels and the final adder.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/halfAdder.sv
// One-bit half adder cell.
// Seeds the carry chain of the final adder.
module halfAdder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b;
  assign cout = a & b;
endmodule

// File: rtl/wallace_reduce_level.sv
// One Wallace level: every group of three rows becomes sum + carry.
// Leftover rows pass through; rows past the live count are zero.
module wallace_reduce_level
  import wallace_pkg::*;
#(
  parameter int W2   = 16,
  parameter int NR   = 9,
  parameter int R_IN = 9
) (
  input  logic [NR-1:0][W2-1:0] rows_i,
  output logic [NR-1:0][W2-1:0] rows_o
);

  localparam int NG    = R_IN / 3;
  localparam int NL    = R_IN % 3;
  localparam int R_OUT = next_rows(R_IN);

  logic [NG-1:0] unused_cy;
  logic          unused_rows;

  for (genvar g = 0; g < NG; g++) begin : g_csa
    logic [W2-1:0] s;
    logic [W2-1:0] c;
    for (genvar k = 0; k < W2; k++) begin : g_bit
      fullAdder u_fa (
        .a   (rows_i[3*g][k]),
        .b   (rows_i[3*g+1][k]),
        .cin (rows_i[3*g+2][k]),
        .sum (s[k]),
        .cout(c[k])
      );
    end
    assign rows_o[2*g]   = s;
    assign rows_o[2*g+1] = {c[W2-2:0], 1'b0};
    assign unused_cy[g]  = c[W2-1];
  end

  for (genvar r = 0; r < NL; r++) begin : g_pass
    assign rows_o[2*NG+r] = rows_i[3*NG+r];
  end

  for (genvar r = R_OUT; r < NR; r++) begin : g_zero
    assign rows_o[r] = '0;
  end

  // Carries out of the top column fall outside the 2*WIDTH result.
  assign unused_rows = ^{unused_cy, rows_i};

endmodule

// File: rtl/wallace_mult_pipe.sv
// Pipelined Wallace-tree multiplier, unsigned or Baugh-Wooley signed.
// A single advance enable moves every stage together.
module wallace_mult_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int W2  = 2 * WIDTH;
  localparam int NR  = WIDTH + 1;
  localparam int NLV = num_levels(NR);
  localparam int LAT = latency(PIPE_STAGES);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("wallace_mult_pipe: WIDTH must be 4..32");
  end
  if (PIPE_STAGES < PIPE_MIN || PIPE_STAGES > PIPE_MAX) begin : g_bad_pipe
    $error("wallace_mult_pipe: PIPE_STAGES must be 1..3");
  end

  typedef logic [NR-1:0][W2-1:0] rows_t;

  rows_t pp;
  rows_t lvl [NLV+1];
  rows_t cur [NLV+1];

  logic             en;
  logic [LAT-1:0]   st_vld;
  logic [LAT-1:0]   st_sgn;
  logic [TAG_W-1:0] st_tag [LAT];

  logic [W2-1:0]    sum;
  logic [W2-1:0]    cy;
  logic             unused_bits;

  logic             out_valid_q, out_valid_d;
  logic [W2-1:0]    out_q, out_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // Row WIDTH carries the Baugh-Wooley correction ones.
  always_comb begin
    pp = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        pp[i][i+j] = (a[j] & b[i]) ^
          (is_signed & ((i == WIDTH-1) != (j == WIDTH-1)));
    if (is_signed) begin
      pp[WIDTH][WIDTH]  = 1'b1;
      pp[WIDTH][W2-1]   = 1'b1;
    end
  end

  assign lvl[0]    = pp;
  assign st_vld[0] = in_valid;
  assign st_sgn[0] = is_signed;
  assign st_tag[0] = in_tag;

  for (genvar l = 0; l <= NLV; l++) begin : g_lvl
    localparam int S = stage_at(l, NLV, PIPE_STAGES);
    if (S != 0) begin : g_reg
      rows_t            rows_q, rows_d;
      logic             vld_q, vld_d;
      logic             sgn_q, sgn_d;
      logic [TAG_W-1:0] tag_q, tag_d;

      always_comb begin
        rows_d = rows_q;
        vld_d  = vld_q;
        sgn_d  = sgn_q;
        tag_d  = tag_q;
        if (en) begin
          rows_d = lvl[l];
          vld_d  = st_vld[S-1];
          sgn_d  = st_sgn[S-1];
          tag_d  = st_tag[S-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rows_q <= '0;
          vld_q  <= 1'b0;
          sgn_q  <= 1'b0;
          tag_q  <= '0;
        end else begin
          rows_q <= rows_d;
          vld_q  <= vld_d;
          sgn_q  <= sgn_d;
          tag_q  <= tag_d;
        end
      end

      assign cur[l]    = rows_q;
      assign st_vld[S] = vld_q;
      assign st_sgn[S] = sgn_q;
      assign st_tag[S] = tag_q;
    end else begin : g_wire
      assign cur[l] = lvl[l];
    end

    if (l < NLV) begin : g_red
      wallace_reduce_level #(
        .W2  (W2),
        .NR  (NR),
        .R_IN(rows_at(NR, l))
      ) u_lvl (
        .rows_i(cur[l]),
        .rows_o(lvl[l+1])
      );
    end
  end

  halfAdder u_ha (
    .a   (cur[NLV][0][0]),
    .b   (cur[NLV][1][0]),
    .sum (sum[0]),
    .cout(cy[0])
  );

  for (genvar k = 1; k < W2; k++) begin : g_cpa
    fullAdder u_fa (
      .a   (cur[NLV][0][k]),
      .b   (cur[NLV][1][k]),
      .cin (cy[k-1]),
      .sum (sum[k]),
      .cout(cy[k])
    );
  end

  assign unused_bits = ^{cy[W2-1], cur[NLV][NR-1:2], st_sgn};

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_tag_d   = out_tag_q;
    if (en) begin
      out_valid_d = st_vld[LAT-1];
      out_d       = sum;
      out_tag_d   = st_tag[LAT-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Scoreboard bench for wallace_mult_pipe: directed, streaming,
// backpressure, reset, and a width/depth sweep.
module tb_wallace_mult_pipe;

  localparam int P = 2;

  typedef struct {
    logic [63:0] p;
    logic [3:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;
  int sw_finished = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic mark_done();
    sw_finished++;
  endtask

  function automatic logic [63:0] model(input int w, input logic [63:0] x,
                                        input logic [63:0] y, input bit s);
    longint sx, sy;
    logic [63:0] m;
    sx = longint'(x);
    sy = longint'(y);
    if (s) begin
      sx = (sx <<< (64 - w)) >>> (64 - w);
      sy = (sy <<< (64 - w)) >>> (64 - w);
    end
    m = (64'd1 << (2 * w)) - 64'd1;
    return 64'(sx * sy) & m;
  endfunction

  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        is_signed;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [3:0]  out_tag;

  wallace_mult_pipe #(
    .WIDTH(8), .PIPE_STAGES(P), .TAG_W(4)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .is_signed(is_signed),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .out_tag  (out_tag)
  );

  exp_t q[$];
  bit   lat_on;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious: out=%0h tag=%0h, expected no result",
                 out, out_tag);
      end else begin
        e = q.pop_front();
        chk("product", 64'(out), e.p);
        chk("tag", 64'(out_tag), 64'(e.tag));
        if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'(P));
      end
    end
  end

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                       input bit s, input logic [3:0] t,
                       input logic [15:0] e);
    bit acc;
    acc = 1'b0;
    in_valid  = 1'b1;
    a         = ia;
    b         = ib;
    is_signed = s;
    in_tag    = t;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        q.push_back('{p: 64'(e), tag: t, cyc: cyc, lat: lat_on});
      end
    end
    chk("accept", 64'(acc), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Width/depth sweep on independent instances.
  function automatic int sw_w(input int k);
    return (k < 2) ? 4 : ((k < 4) ? 8 : 16);
  endfunction

  function automatic int sw_p(input int k);
    return (k % 2 == 1) ? 3 : 1;
  endfunction

  logic rst_sw_n;
  initial begin
    rst_sw_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_sw_n = 1'b1;
  end

  for (genvar k = 0; k < 6; k++) begin : g_sw
    localparam int SW = sw_w(k);
    localparam int SP = sw_p(k);

    logic          iv, ir, sg, ov, ordy;
    logic [SW-1:0] xa, xb;
    logic [3:0]    it, ot;
    logic [2*SW-1:0] op;
    exp_t sq[$];

    wallace_mult_pipe #(
      .WIDTH(SW), .PIPE_STAGES(SP), .TAG_W(4)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_sw_n),
      .in_valid (iv),
      .in_ready (ir),
      .a        (xa),
      .b        (xb),
      .is_signed(sg),
      .in_tag   (it),
      .out_valid(ov),
      .out_ready(ordy),
      .out      (op),
      .out_tag  (ot)
    );

    initial begin
      int n;
      iv = 1'b0; xa = '0; xb = '0; sg = 1'b0; it = '0; ordy = 1'b1;
      n = (SW == 4) ? 512 : 120;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < n; i++) begin
        if (SW == 4) begin
          sg = i[8];
          xa = SW'(i >> 4);
          xb = SW'(i);
        end else begin
          sg = i[0];
          xa = SW'($urandom());
          xb = SW'($urandom());
        end
        iv = 1'b1;
        it = 4'(i);
        @(negedge clk);
        chk($sformatf("sw%0d_p%0d_accept", SW, SP), 64'(ir), 64'd1);
        sq.push_back('{p: model(SW, 64'(xa), 64'(xb), sg), tag: 4'(i),
                       cyc: cyc, lat: 1'b1});
        @(posedge clk);
        #1;
      end
      iv = 1'b0;
      for (int t = 0; t < 50 && sq.size() != 0; t++) @(negedge clk);
      chk($sformatf("sw%0d_p%0d_drain", SW, SP), 64'(sq.size()), 64'd0);
      mark_done();
    end

    always @(negedge clk) begin
      exp_t e;
      if (rst_sw_n && ov) begin
        if (sq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sw%0d_p%0d_spurious: out=%0h, expected no result",
                   SW, SP, op);
        end else begin
          e = sq.pop_front();
          chk($sformatf("sw%0d_p%0d_product", SW, SP), 64'(op), e.p);
          chk($sformatf("sw%0d_p%0d_tag", SW, SP), 64'(ot), 64'(e.tag));
          chk($sformatf("sw%0d_p%0d_latency", SW, SP),
              64'(cyc - e.cyc), 64'(SP));
        end
      end
    end
  end

  initial begin
    logic [7:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    is_signed = 1'b0; in_tag = '0; out_ready = 1'b1; lat_on = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_out_valid", 64'(out_valid), 64'd0);

    issue(8'hFF, 8'hFF, 1'b0, 4'h5, 16'hFE01);
    drain();

    issue(8'h80, 8'h80, 1'b1, 4'h1, 16'h4000);
    issue(8'hFF, 8'h01, 1'b1, 4'h2, 16'hFFFF);
    issue(8'h80, 8'h7F, 1'b1, 4'h3, 16'hC080);
    issue(8'h80, 8'h80, 1'b0, 4'h4, 16'h4000);
    issue(8'hFF, 8'h01, 1'b0, 4'h6, 16'h00FF);
    issue(8'h80, 8'h7F, 1'b0, 4'h7, 16'h3F80);
    issue(8'h7F, 8'h7F, 1'b1, 4'h8, 16'h3F01);
    issue(8'hFF, 8'hFF, 1'b1, 4'h9, 16'h0001);
    issue(8'h00, 8'h80, 1'b1, 4'hA, 16'h0000);
    drain();

    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom());
      rb = 8'($urandom());
      issue(ra, rb, i[0], 4'(i), 16'(model(8, 64'(ra), 64'(rb), i[0])));
    end
    drain();

    lat_on = 1'b0;
    out_ready = 1'b0;
    issue(8'd12, 8'd13, 1'b0, 4'hA, 16'd156);
    issue(8'hF6, 8'd7, 1'b1, 4'hB, 16'hFFBA);
    in_valid = 1'b1; a = 8'd3; b = 8'd5; is_signed = 1'b0; in_tag = 4'hC;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out", 64'(out), q[0].p);
      chk("bp_out_tag", 64'(out_tag), 64'(q[0].tag));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(8'd3, 8'd5, 1'b0, 4'hC, 16'd15);
    drain();

    issue(8'd2, 8'd3, 1'b0, 4'h1, 16'd6);
    issue(8'd4, 8'd5, 1'b0, 4'h2, 16'd20);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out", 64'(out), 64'd0);
    chk("mid_rst_out_tag", 64'(out_tag), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    lat_on = 1'b1;
    issue(8'd9, 8'd9, 1'b1, 4'h3, 16'd81);
    drain();

    for (int t = 0; t < 5000 && sw_finished < 6; t++) @(posedge clk);
    chk("sweep_done", 64'(sw_finished), 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
